switch_port_receiver: RTL and testbench

Synthesizable drain stage that sits directly downstream of one router output port (`data_N`/`ready_N`/`read_N`). It requests bytes with `read`, reassembles each packet (DA, SA, LEN, LEN payload bytes, FCS; LEN+4 bytes total) and checks it. It then reports per-packet status and a byte stream to the scoreboard. The environment instantiates four copies, one per port, with `PORT_ID` 0-3.

---
 rtl/switch_port_receiver.sv | 157 +++++++++++++++
 tb/tb_switch_port_receiver.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_port_receiver.sv
// switch_port_receiver: drains one router output port, reassembles each
// packet (DA, SA, LEN, payload, FCS), checks it and reports status plus a
// captured byte stream.
module switch_port_receiver #(
    parameter int PORT_ID = 0,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ready,
    input  logic [7:0]       data,
    output logic             read,
    output logic             byte_valid,
    output logic [7:0]       byte_data,
    output logic [7:0]       byte_idx,
    output logic             pkt_done,
    output logic             pkt_ok,
    output logic             err_da,
    output logic             err_fcs,
    output logic             err_trunc,
    output logic [7:0]       pkt_da,
    output logic [7:0]       pkt_sa,
    output logic [7:0]       pkt_len,
    output logic [CNT_W-1:0] pkt_count
);
    localparam logic [7:0] PORT_BYTE = 8'(PORT_ID);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    // Request/capture counters are 9 bits so a 259-byte packet never wraps.
    logic [8:0] req_cnt, req_nxt, cap_cnt, total;
    logic       read_p1;
    logic       trunc;
    logic [7:0] run_xor, hdr_da, hdr_sa, hdr_len, len_now;
    logic       len_here, len_known, last_req, is_fcs, got_da;
    logic       bad_da, bad_fcs;
    logic       start, stop, cut, finish;

    // Length decode: LEN is used straight off the bus in its capture cycle so
    // that a zero-length packet still stops after four requests.
    always_comb begin
        len_here  = read_p1 && (cap_cnt == 9'd2);
        len_now   = len_here ? data : hdr_len;
        len_known = len_here || (cap_cnt >= 9'd3);
        total     = {1'b0, len_now} + 9'd4;
        req_nxt   = req_cnt + 9'd1;
        last_req  = len_known && (req_nxt == total);
        is_fcs    = (cap_cnt >= 9'd3) && (cap_cnt == ({1'b0, hdr_len} + 9'd3));
        got_da    = (cap_cnt != 9'd0);
        bad_da    = got_da && (hdr_da != PORT_BYTE);
        bad_fcs   = !trunc && (run_xor != byte_data);
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ready) state_nxt = REQ;
            REQ:     if (last_req || !ready) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM control strobes
    always_comb begin
        start  = (state == IDLE) && ready;
        stop   = (state == REQ) && (last_req || !ready);
        cut    = (state == REQ) && !last_req && !ready;
        finish = (state == DONE);
    end

    // Request generation and byte capture; data arrives one cycle after read
    always_ff @(posedge clock) begin
        if (reset) begin
            read       <= 1'b0;
            read_p1    <= 1'b0;
            req_cnt    <= 9'd0;
            cap_cnt    <= 9'd0;
            trunc      <= 1'b0;
            byte_valid <= 1'b0;
            byte_data  <= 8'd0;
            byte_idx   <= 8'd0;
        end else begin
            read_p1    <= read;
            byte_valid <= read_p1;
            if (start) begin
                read    <= 1'b1;
                req_cnt <= 9'd0;
                cap_cnt <= 9'd0;
                trunc   <= 1'b0;
            end else if (state == REQ) begin
                req_cnt <= req_nxt;
                if (stop) read  <= 1'b0;
                if (cut)  trunc <= 1'b1;
            end
            if (read_p1) begin
                byte_data <= data;
                byte_idx  <= cap_cnt[7:0];
                cap_cnt   <= cap_cnt + 9'd1;
            end
        end
    end

    // Running FCS and header capture for the packet in flight
    always_ff @(posedge clock) begin
        if (start) begin
            run_xor <= 8'd0;
            hdr_da  <= 8'd0;
            hdr_sa  <= 8'd0;
            hdr_len <= 8'd0;
        end else if (read_p1) begin
            if (!is_fcs) run_xor <= run_xor ^ data;
            case (cap_cnt)
                9'd0:    hdr_da  <= data;
                9'd1:    hdr_sa  <= data;
                9'd2:    hdr_len <= data;
                default: ;
            endcase
        end
    end

    // Per-packet status, held until the next completed packet
    always_ff @(posedge clock) begin
        if (reset) begin
            pkt_done  <= 1'b0;
            pkt_ok    <= 1'b0;
            err_da    <= 1'b0;
            err_fcs   <= 1'b0;
            err_trunc <= 1'b0;
            pkt_da    <= 8'd0;
            pkt_sa    <= 8'd0;
            pkt_len   <= 8'd0;
            pkt_count <= '0;
        end else begin
            pkt_done <= finish;
            if (finish) begin
                err_da    <= bad_da;
                err_fcs   <= bad_fcs;
                err_trunc <= trunc;
                pkt_ok    <= !bad_da && !bad_fcs && !trunc;
                pkt_da    <= hdr_da;
                pkt_sa    <= hdr_sa;
                pkt_len   <= hdr_len;
                pkt_count <= pkt_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_switch_port_receiver.sv
// Bench for switch_port_receiver: a router model feeds packet bytes on read
// requests, a scoreboard checks every captured byte and every status report.
module tb_switch_port_receiver;
    logic       clock;
    logic       reset;
    logic       ready;
    logic [7:0] data;

    logic        read, byte_valid, pkt_done, pkt_ok, err_da, err_fcs, err_trunc;
    logic [7:0]  byte_data, byte_idx, pkt_da, pkt_sa, pkt_len;
    logic [15:0] pkt_count;

    logic        read_b, byte_valid_b, pkt_done_b, pkt_ok_b, err_da_b, err_fcs_b, err_trunc_b;
    logic [7:0]  byte_data_b, byte_idx_b, pkt_da_b, pkt_sa_b, pkt_len_b;
    logic [1:0]  pkt_count_b;

    switch_port_receiver #(.PORT_ID(2), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .ready(ready), .data(data),
        .read(read), .byte_valid(byte_valid), .byte_data(byte_data), .byte_idx(byte_idx),
        .pkt_done(pkt_done), .pkt_ok(pkt_ok), .err_da(err_da), .err_fcs(err_fcs),
        .err_trunc(err_trunc), .pkt_da(pkt_da), .pkt_sa(pkt_sa), .pkt_len(pkt_len),
        .pkt_count(pkt_count)
    );

    switch_port_receiver #(.PORT_ID(2), .CNT_W(2)) dut_c2 (
        .clock(clock), .reset(reset), .ready(ready), .data(data),
        .read(read_b), .byte_valid(byte_valid_b), .byte_data(byte_data_b), .byte_idx(byte_idx_b),
        .pkt_done(pkt_done_b), .pkt_ok(pkt_ok_b), .err_da(err_da_b), .err_fcs(err_fcs_b),
        .err_trunc(err_trunc_b), .pkt_da(pkt_da_b), .pkt_sa(pkt_sa_b), .pkt_len(pkt_len_b),
        .pkt_count(pkt_count_b)
    );

    typedef struct {
        logic [7:0] b;
        logic [8:0] idx;
    } byte_t;

    typedef struct {
        logic       ok, eda, efcs, etr;
        logic [7:0] da, sa, len;
        int         nbytes;
    } stat_t;

    typedef struct {
        logic [7:0] da, sa, len;
        logic       flip;
        int         cut;
        logic       ok, eda, efcs, etr;
        logic [7:0] elen;
    } vec_t;

    byte_t src_q[$];
    byte_t exp_b_q[$];
    stat_t stat_q[$];
    vec_t  vecs[7];

    int   compared = 0;
    int   mismatched = 0;
    int   valid_since_done = 0;
    int   exp_cnt = 0;
    logic rd_neg = 1'b0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Router model: read seen during a cycle yields a byte on the next cycle
    initial begin
        forever begin
            @(negedge clock);
            rd_neg = read;
        end
    end

    initial begin
        byte_t e;
        data = 8'd0;
        forever begin
            @(posedge clock);
            #1;
            if (rd_neg) begin
                if (src_q.size() > 0) begin
                    e = src_q.pop_front();
                    data = e.b;
                    exp_b_q.push_back(e);
                end else begin
                    data = 8'd0;
                end
            end
        end
    end

    // Scoreboard monitor
    initial begin
        byte_t e;
        stat_t s;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (byte_valid) begin
                    valid_since_done++;
                    if (exp_b_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL byte_extra: got byte 0x%0h idx %0d, want none", byte_data, byte_idx);
                    end else begin
                        e = exp_b_q.pop_front();
                        check("byte_data", 32'(byte_data), 32'(e.b));
                        check("byte_idx", 32'(byte_idx), 32'(e.idx[7:0]));
                    end
                end
                if (pkt_done) begin
                    if (stat_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL pkt_done_extra: got pkt_done=1, want 0");
                    end else begin
                        s = stat_q.pop_front();
                        check("pkt_ok", 32'(pkt_ok), 32'(s.ok));
                        check("err_da", 32'(err_da), 32'(s.eda));
                        check("err_fcs", 32'(err_fcs), 32'(s.efcs));
                        check("err_trunc", 32'(err_trunc), 32'(s.etr));
                        check("pkt_da", 32'(pkt_da), 32'(s.da));
                        check("pkt_sa", 32'(pkt_sa), 32'(s.sa));
                        check("pkt_len", 32'(pkt_len), 32'(s.len));
                        check("strobes", 32'(valid_since_done), 32'(s.nbytes));
                    end
                    valid_since_done = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load_pkt(input logic [7:0] da, input logic [7:0] sa,
                            input logic [7:0] len, input logic flip);
        logic [7:0] x;
        byte_t e;
        x = da ^ sa ^ len;
        e.b = da;  e.idx = 9'd0; src_q.push_back(e);
        e.b = sa;  e.idx = 9'd1; src_q.push_back(e);
        e.b = len; e.idx = 9'd2; src_q.push_back(e);
        for (int i = 0; i < int'(len); i++) begin
            e.b = 8'(i + 1);
            e.idx = 9'(i + 3);
            x ^= e.b;
            src_q.push_back(e);
        end
        e.b = x ^ {7'd0, flip};
        e.idx = {1'b0, len} + 9'd3;
        src_q.push_back(e);
    endtask

    task automatic run_pkt(input vec_t v);
        stat_t s;
        int    n, reads, guard;
        logic  done_seen;
        load_pkt(v.da, v.sa, v.len, v.flip);
        n = (v.cut == 0) ? int'(v.len) + 4 : v.cut;
        s.ok = v.ok; s.eda = v.eda; s.efcs = v.efcs; s.etr = v.etr;
        s.da = v.da; s.sa = v.sa; s.len = v.elen; s.nbytes = n;
        stat_q.push_back(s);
        exp_cnt++;
        ready = 1'b1;
        reads = 0;
        guard = 0;
        while (reads < n && guard < 400) begin
            @(negedge clock);
            if (read) reads++;
            guard++;
        end
        ready = 1'b0;
        check("req_in_time", 32'(guard < 400), 32'd1);
        done_seen = 1'b0;
        guard = 0;
        while (!done_seen && guard < 20) begin
            @(negedge clock);
            if (read) reads++;
            if (pkt_done) done_seen = 1'b1;
            guard++;
        end
        check("pkt_done_seen", 32'(done_seen), 32'd1);
        check("read_cycles", 32'(reads), 32'(n));
        check("pkt_count", 32'(pkt_count), 32'(exp_cnt));
        src_q.delete();
        repeat (3) @(posedge clock);
        #1;
    endtask

    initial begin
        vec_t v;
        int   reads, dones, guard;
        stat_t s;

        //            da     sa     len    flip  cut  ok    eda   efcs  etr   elen
        vecs[0] = '{8'h02, 8'h11, 8'd5,  1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5};
        vecs[1] = '{8'h02, 8'h00, 8'd0,  1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[2] = '{8'h02, 8'h11, 8'd5,  1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5};
        vecs[3] = '{8'h03, 8'h11, 8'd5,  1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5};
        vecs[4] = '{8'h02, 8'h22, 8'd10, 1'b0, 6, 1'b0, 1'b0, 1'b0, 1'b1, 8'd10};
        vecs[5] = '{8'h00, 8'h01, 8'd1,  1'b0, 2, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
        vecs[6] = '{8'h01, 8'h7f, 8'd2,  1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2};

        reset = 1'b1;
        ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_read", 32'(read), 32'd0);
        check("rst_byte_valid", 32'(byte_valid), 32'd0);
        check("rst_byte_data", 32'(byte_data), 32'd0);
        check("rst_pkt_done", 32'(pkt_done), 32'd0);
        check("rst_pkt_ok", 32'(pkt_ok), 32'd0);
        check("rst_errs", 32'({err_da, err_fcs, err_trunc}), 32'd0);
        check("rst_hdr", 32'({pkt_da, pkt_sa, pkt_len}), 32'd0);
        check("rst_pkt_count", 32'(pkt_count), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        for (int i = 0; i < 7; i++) run_pkt(vecs[i]);

        // Reset in the middle of a LEN=20 packet
        load_pkt(8'h02, 8'h33, 8'd20, 1'b0);
        ready = 1'b1;
        reads = 0;
        guard = 0;
        while (reads < 3 && guard < 50) begin
            @(negedge clock);
            if (read) reads++;
            guard++;
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        ready = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("midrst_read", 32'(read), 32'd0);
        check("midrst_pkt_done", 32'(pkt_done), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        src_q.delete();
        exp_b_q.delete();
        valid_since_done = 0;
        exp_cnt = 0;
        check("midrst_pkt_count", 32'(pkt_count), 32'd0);
        reset = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        check("midrst_count_after", 32'(pkt_count), 32'd0);
        v = '{8'h02, 8'h44, 8'd3, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3};
        run_pkt(v);

        // Clear counters, then ten back-to-back maximum-length packets
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst2_count", 32'(pkt_count), 32'd0);
        check("rst2_count_c2", 32'(pkt_count_b), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_cnt = 0;
        valid_since_done = 0;
        @(posedge clock);
        #1;
        for (int p = 0; p < 10; p++) begin
            load_pkt(8'h02, 8'(p), 8'd255, 1'b0);
            s.ok = 1'b1; s.eda = 1'b0; s.efcs = 1'b0; s.etr = 1'b0;
            s.da = 8'h02; s.sa = 8'(p); s.len = 8'd255; s.nbytes = 259;
            stat_q.push_back(s);
        end
        ready = 1'b1;
        reads = 0;
        dones = 0;
        guard = 0;
        while (dones < 10 && guard < 4000) begin
            @(negedge clock);
            if (read) reads++;
            if (pkt_done) dones++;
            guard++;
        end
        ready = 1'b0;
        check("b2b_dones", 32'(dones), 32'd10);
        check("b2b_read_cycles", 32'(reads), 32'd2590);
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("b2b_pkt_count", 32'(pkt_count), 32'd10);
        check("b2b_pkt_count_c2", 32'(pkt_count_b), 32'd2);
        check("b2b_read_idle", 32'(read), 32'd0);
        check("sb_bytes_left", 32'(exp_b_q.size()), 32'd0);
        check("sb_stats_left", 32'(stat_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
